rdma_sq_credit_sched: RTL and testbench

Credit-gated round-robin scheduler between per-vFPGA RDMA send-queue requesters and the single send-queue port of the RDMA stack. It sits in the RDMA arbitration layer in front of the network SQ interface. It grants one region at a time, tags the forwarded request with the source vFID, and caps each region's outstanding (un-ACKed) requests. Outstanding counts are returned by ACKs from the stack, so no single vFPGA can monopolise the stack's queue.

---
 rtl/rdma_sq_credit_sched_pkg.sv | 14 +
 rtl/rdma_sq_rr_pick.sv | 36 +++
 rtl/rdma_sq_credit_sched.sv | 140 ++++++++++++++
 tb/tb_rdma_sq_credit_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_sq_credit_sched_pkg.sv
// Shared constants and types for the RDMA send-queue credit scheduler and its picker.
package rdma_sq_credit_sched_pkg;

  localparam int unsigned N_REGIONS       = 4;
  localparam int unsigned N_REGIONS_BITS  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned RDMA_SQ_MAX_OUT = 16;
  localparam int unsigned RDMA_SQ_CNT_W   = $clog2(RDMA_SQ_MAX_OUT + 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sq_state_e;

endpackage

// File: rtl/rdma_sq_rr_pick.sv
// Combinational rotate-priority picker: first set elig bit at or above rr_ptr, wrapping.
module rdma_sq_rr_pick
  import rdma_sq_credit_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REGIONS,
  parameter int unsigned IDX_W = N_REGIONS_BITS
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             found_c,
  output logic [IDX_W-1:0] pick_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [N_REQ-1:0] rot_c;
  logic [SUM_W-1:0] sum_c;

  // Rotate so bit 0 is rr_ptr, take the lowest set bit, then map the offset back.
  always_comb begin
    rot_c   = N_REQ'({elig_i, elig_i} >> rr_ptr_i);
    found_c = 1'b0;
    sum_c   = SUM_W'(rr_ptr_i);
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (rot_c[k]) begin
        found_c = 1'b1;
        sum_c   = SUM_W'(rr_ptr_i) + SUM_W'(k);
      end
    end
    if (sum_c >= SUM_W'(N_REQ)) begin
      sum_c = sum_c - SUM_W'(N_REQ);
    end
    pick_c = IDX_W'(sum_c);
  end

endmodule

// File: rtl/rdma_sq_credit_sched.sv
// Credit-gated round-robin scheduler from per-region SQ requesters onto the single stack SQ port.
// Each region is capped in un-ACKed requests; ACKs from the stack return the credits.
module rdma_sq_credit_sched
  import rdma_sq_credit_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REGIONS,
  parameter int unsigned REQ_W   = 256,
  parameter int unsigned MAX_OUT = RDMA_SQ_MAX_OUT,
  parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1),
  parameter int unsigned VFID_W  = N_REGIONS_BITS
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_REQ-1:0]       s_sq_valid,
  output logic [N_REQ-1:0]       s_sq_ready,
  input  logic [N_REQ*REQ_W-1:0] s_sq_data,
  output logic                   m_sq_valid,
  input  logic                   m_sq_ready,
  output logic [REQ_W-1:0]       m_sq_data,
  output logic [VFID_W-1:0]      m_sq_vfid,
  input  logic                   s_ack_valid,
  input  logic [VFID_W-1:0]      s_ack_vfid,
  input  logic [CNT_W-1:0]       cfg_max_out,
  output logic                   err_ack_underflow,
  output logic [N_REQ-1:0]       stat_busy
);

  localparam int unsigned SUM_W = VFID_W + 1;

  sq_state_e         state_q, state_d;
  logic [VFID_W-1:0] rr_q, rr_d;
  logic [VFID_W-1:0] vfid_q, vfid_d;
  logic [REQ_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  cnt_q [N_REQ];
  logic [CNT_W-1:0]  cnt_d [N_REQ];
  logic              err_q, err_d;
  logic [N_REQ-1:0]  busy_q, busy_d;

  logic [CNT_W-1:0]  limit_c;
  logic [N_REQ-1:0]  elig_c, inc_c, dec_c;
  logic              found_c, load_c, grant_c;
  logic [VFID_W-1:0] pick_c;
  logic [REQ_W-1:0]  sel_data_c;
  logic [SUM_W-1:0]  rr_sum_c;

  // Effective per-region limit and eligibility; cfg above the hard ceiling saturates.
  always_comb begin
    limit_c = (cfg_max_out > CNT_W'(MAX_OUT)) ? CNT_W'(MAX_OUT) : cfg_max_out;
    for (int i = 0; i < int'(N_REQ); i++) begin
      elig_c[i] = s_sq_valid[i] && (cnt_q[i] < limit_c);
    end
  end

  rdma_sq_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (VFID_W)
  ) u_pick (
    .elig_i   (elig_c),
    .rr_ptr_i (rr_q),
    .found_c  (found_c),
    .pick_c   (pick_c)
  );

  assign load_c  = (state_q == ST_EMPTY) || (m_sq_valid && m_sq_ready);
  assign grant_c = load_c && found_c;

  // Per-region grant/ACK strobes and the granted data word.
  always_comb begin
    sel_data_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      inc_c[i] = grant_c && (pick_c == VFID_W'(i));
      dec_c[i] = s_ack_valid && (s_ack_vfid == VFID_W'(i)) && (cnt_q[i] != '0);
      if (pick_c == VFID_W'(i)) begin
        sel_data_c = s_sq_data[i*REQ_W +: REQ_W];
      end
    end
  end

  assign rr_sum_c = SUM_W'(pick_c) + SUM_W'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    vfid_d  = vfid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = '0;
    // An ACK that releases no credit (idle region or out-of-range vfid) is an error.
    err_d   = err_q || (s_ack_valid && !(|dec_c));
    if (load_c) begin
      if (found_c) begin
        state_d = ST_FULL;
        data_d  = sel_data_c;
        vfid_d  = pick_c;
        rr_d    = (rr_sum_c >= SUM_W'(N_REQ)) ? '0 : VFID_W'(rr_sum_c);
      end else begin
        state_d = ST_EMPTY;
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (inc_c[i] && !dec_c[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!inc_c[i] && dec_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      rr_q    <= '0;
      vfid_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      vfid_q  <= vfid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is gated by reset so nothing handshakes while the block is held in reset.
  assign s_sq_ready        = aresetn ? inc_c : '0;
  assign m_sq_valid        = (state_q == ST_FULL);
  assign m_sq_data         = data_q;
  assign m_sq_vfid         = vfid_q;
  assign err_ack_underflow = err_q;
  assign stat_busy         = busy_q;

endmodule

// File: tb/tb_rdma_sq_credit_sched.sv
// Bench for rdma_sq_credit_sched: directed scenarios plus randomized traffic against a queue-level model.
module tb_rdma_sq_credit_sched;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NR-1:0]   s_sq_valid = '0;
  logic [NR-1:0]   s_sq_ready;
  logic [NR*DW-1:0] s_sq_data = '0;
  logic            m_sq_valid;
  logic            m_sq_ready = 1'b0;
  logic [DW-1:0]   m_sq_data;
  logic [2:0]      m_sq_vfid;
  logic            s_ack_valid = 1'b0;
  logic [2:0]      s_ack_vfid = '0;
  logic [4:0]      cfg_max_out = 5'd16;
  logic            err_ack_underflow;
  logic [NR-1:0]   stat_busy;

  rdma_sq_credit_sched #(
    .N_REQ(NR), .REQ_W(DW), .MAX_OUT(16), .CNT_W(5), .VFID_W(3)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data), .m_sq_vfid(m_sq_vfid),
    .s_ack_valid(s_ack_valid), .s_ack_vfid(s_ack_vfid), .cfg_max_out(cfg_max_out),
    .err_ack_underflow(err_ack_underflow), .stat_busy(stat_busy)
  );

  always #5 aclk = ~aclk;

  int n_pass = 0;
  int n_total = 0;

  // Model: one held slot, per-region outstanding counts, rotating pointer, sticky error.
  int          mdl_cnt [NR];
  int          mdl_rr;
  bit          mdl_full;
  logic [DW-1:0] mdl_data;
  int          mdl_vfid;
  bit          mdl_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl_cnt[i] = 0;
    mdl_rr = 0; mdl_full = 0; mdl_data = '0; mdl_vfid = 0; mdl_err = 0;
  endtask

  // Region the model would grant this cycle, or -1.
  function automatic int pick_model();
    int lim;
    lim = (int'(cfg_max_out) > 16) ? 16 : int'(cfg_max_out);
    if (mdl_full && !m_sq_ready) return -1;
    for (int k = 0; k < NR; k++) begin
      int r;
      r = (mdl_rr + k) % NR;
      if (s_sq_valid[r] && mdl_cnt[r] < lim) return r;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int p;
    if (!aresetn) return '0;
    p = pick_model();
    return (p < 0) ? '0 : NR'(1 << p);
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] b;
    for (int i = 0; i < NR; i++) b[i] = (mdl_cnt[i] != 0);
    return b;
  endfunction

  task automatic model_update();
    int g, v;
    int old [NR];
    if (!aresetn) begin model_reset(); return; end
    g = pick_model();
    for (int i = 0; i < NR; i++) old[i] = mdl_cnt[i];
    if (!mdl_full || m_sq_ready) begin
      if (g >= 0) begin
        mdl_full = 1; mdl_data = s_sq_data[g*DW +: DW]; mdl_vfid = g;
        mdl_rr = (g + 1) % NR; mdl_cnt[g]++;
      end else begin
        mdl_full = 0;
      end
    end
    if (s_ack_valid) begin
      v = int'(s_ack_vfid);
      if (v < NR && old[v] > 0) mdl_cnt[v]--;
      else mdl_err = 1;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge aclk) begin
    check("s_sq_ready", 64'(s_sq_ready), 64'(exp_ready()));
    check("m_sq_valid", 64'(m_sq_valid), 64'(mdl_full));
    if (mdl_full) begin
      check("m_sq_data", 64'(m_sq_data), 64'(mdl_data));
      check("m_sq_vfid", 64'(m_sq_vfid), 64'(mdl_vfid));
    end
    check("err_ack_underflow", 64'(err_ack_underflow), 64'(mdl_err));
    check("stat_busy", 64'(stat_busy), 64'(exp_busy()));
  end

  task automatic step();
    @(posedge aclk);
    model_update();
    #1;
  endtask

  task automatic quiet_inputs();
    s_sq_valid = '0; s_ack_valid = 1'b0; s_ack_vfid = '0; m_sq_ready = 1'b0; cfg_max_out = 5'd16;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    model_reset();
    quiet_inputs();
    repeat (3) step();
    aresetn = 1'b1;
  endtask

  task automatic rand_phase(input int n);
    for (int c = 0; c < n; c++) begin
      int v;
      s_sq_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) s_sq_data[i*DW +: DW] = $urandom;
      m_sq_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 4))
          0: cfg_max_out = 5'd1;
          1: cfg_max_out = 5'd3;
          2: cfg_max_out = 5'd0;
          3: cfg_max_out = 5'($urandom);
          default: cfg_max_out = 5'd16;
        endcase
      end
      v = $urandom_range(0, 3);
      s_ack_valid = ($urandom_range(0, 2) != 0) && (mdl_cnt[v] != 0 || $urandom_range(0, 15) == 0);
      s_ack_vfid = ($urandom_range(0, 199) == 0) ? 3'($urandom_range(4, 7)) : 3'(v);
      step();
    end
    quiet_inputs();
  endtask

  int n_gr;
  bit first_gr;

  initial begin
    model_reset();
    do_reset();
    check("reset_m_valid", 64'(m_sq_valid), 64'd0);
    check("reset_err", 64'(err_ack_underflow), 64'd0);
    check("reset_busy", 64'(stat_busy), 64'd0);

    // Round robin with every region valid and each forwarded request ACKed.
    for (int i = 0; i < NR; i++) s_sq_data[i*DW +: DW] = 32'(32'h100 + i);
    s_sq_valid = 4'hF; m_sq_ready = 1'b1;
    #1;
    check("rr_first_ready", 64'(s_sq_ready), 64'd1);
    check("rr_first_valid", 64'(m_sq_valid), 64'd0);
    for (int j = 0; j < 8; j++) begin
      s_ack_valid = mdl_full; s_ack_vfid = 3'(mdl_vfid);
      step();
      check("rr_vfid", 64'(m_sq_vfid), 64'(j % 4));
      check("rr_valid", 64'(m_sq_valid), 64'd1);
    end
    s_ack_valid = 1'b0;

    // Credit cap of 2 on region 1, then one ACK buys exactly one more grant.
    do_reset();
    cfg_max_out = 5'd2; s_sq_valid = 4'b0010; m_sq_ready = 1'b1;
    n_gr = 0;
    for (int c = 0; c < 6; c++) begin #1; n_gr += int'(s_sq_ready[1]); step(); end
    check("cap_grants", 64'(n_gr), 64'd2);
    s_ack_valid = 1'b1; s_ack_vfid = 3'd1;
    #1;
    check("cap_ack_cycle_ready", 64'(s_sq_ready[1]), 64'd0);
    step();
    s_ack_valid = 1'b0;
    n_gr = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 0) first_gr = s_sq_ready[1];
      n_gr += int'(s_sq_ready[1]);
      step();
    end
    check("cap_regrant_next_cycle", 64'(first_gr), 64'd1);
    check("cap_regrants", 64'(n_gr), 64'd1);

    // Backpressure holds 0xA5 stable and blocks all grants.
    do_reset();
    s_sq_valid = 4'b0001; s_sq_data[0 +: DW] = 32'hA5; m_sq_ready = 1'b0;
    step();
    s_sq_valid = 4'b0101; s_sq_data[0 +: DW] = 32'h11; s_sq_data[2*DW +: DW] = 32'h22;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_data", 64'(m_sq_data), 64'hA5);
      check("bp_vfid", 64'(m_sq_vfid), 64'd0);
      check("bp_ready", 64'(s_sq_ready), 64'd0);
      step();
    end
    m_sq_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(s_sq_ready), 64'b0100);
    step();
    check("bp_next_data", 64'(m_sq_data), 64'h22);
    check("bp_next_vfid", 64'(m_sq_vfid), 64'd2);

    // Simultaneous ACK and grant on region 2 at count 3, then underflow on region 3.
    do_reset();
    s_sq_valid = 4'b0100; m_sq_ready = 1'b1;
    repeat (3) step();
    check("sim_model_cnt", 64'(mdl_cnt[2]), 64'd3);
    s_ack_valid = 1'b1; s_ack_vfid = 3'd2;
    step();
    s_ack_valid = 1'b0; s_sq_valid = '0;
    check("sim_cnt2", 64'(dut.cnt_q[2]), 64'd3);
    check("sim_err", 64'(err_ack_underflow), 64'd0);
    s_ack_valid = 1'b1; s_ack_vfid = 3'd3;
    step();
    s_ack_valid = 1'b0;
    check("uf_err", 64'(err_ack_underflow), 64'd1);
    check("uf_cnt2", 64'(dut.cnt_q[2]), 64'd3);
    check("uf_cnt3", 64'(dut.cnt_q[3]), 64'd0);
    repeat (3) step();
    check("uf_sticky", 64'(err_ack_underflow), 64'd1);
    do_reset();
    check("uf_cleared", 64'(err_ack_underflow), 64'd0);
    s_ack_valid = 1'b1; s_ack_vfid = 3'd5;
    step();
    s_ack_valid = 1'b0;
    check("uf_bad_vfid", 64'(err_ack_underflow), 64'd1);

    // Reset mid-operation with counts {1,2,0,4} and a held request.
    do_reset();
    m_sq_ready = 1'b1;
    s_sq_valid = 4'b0001; step();
    s_sq_valid = 4'b0010; repeat (2) step();
    s_sq_valid = 4'b1000; repeat (4) step();
    check("mid_model_cnt0", 64'(mdl_cnt[0]), 64'd1);
    check("mid_model_cnt1", 64'(mdl_cnt[1]), 64'd2);
    check("mid_model_cnt3", 64'(mdl_cnt[3]), 64'd4);
    check("mid_held", 64'(m_sq_valid), 64'd1);
    s_sq_valid = 4'hF;
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", 64'(m_sq_valid), 64'd0);
    check("mid_rst_ready", 64'(s_sq_ready), 64'd0);
    check("mid_rst_busy", 64'(stat_busy), 64'd0);
    check("mid_rst_data", 64'(m_sq_data), 64'd0);
    check("mid_rst_rr", 64'(dut.rr_q), 64'd0);
    for (int i = 0; i < NR; i++) check("mid_rst_cnt", 64'(dut.cnt_q[i]), 64'd0);
    repeat (2) step();
    aresetn = 1'b1;
    #1;
    check("mid_post_ready", 64'(s_sq_ready), 64'b0001);
    step();
    check("mid_post_vfid", 64'(m_sq_vfid), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    rand_phase(3000);
    do_reset();
    rand_phase(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
